time_set_controller: RTL and testbench
======================================

# time_set_controller

Sequencer that replaces switch-based digit selection on the wall clock with a two-button set-time interface. It debounces the select and advance keys and steps through the six digit fields (seconds through tens-of-hours). It issues one-cycle advance strobes toward the selected digit counter, a blink phase for the blinkers, and a run-enable that freezes timekeeping while a field is being set. It sits between the KEY inputs and the counter/blinker chain, clocked from CLOCK_50.

## Interface
- DEBOUNCE_CYCLES, 20'd500_000: consecutive stable samples required before a key level is accepted (10 ms at 50 MHz).
- BLINK_HALF_PERIOD, 25'd12_500_000: cycles per blink phase (4 Hz toggle at 50 MHz).
- TIMEOUT_CYCLES, 30'd500_000_000: idle cycles before setting mode is abandoned (10 s). Present only with the timeout feature.
- inputClock, input, 1: single clock. All logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- select_key_n, input, 1: raw KEY[3], active-low, asynchronous to inputClock.
- advance_key_n, input, 1: raw KEY[2], active-low, asynchronous to inputClock.
- selected, output, 4: field code. 0 = NONE_SELECTED, 1 = SECONDS, 2 = SECONDSx10, 3 = MINUTES, 4 = MINUTESx10, 5 = HOURS, 6 = HOURSx10.
- advance_pulse, output, 1: one-cycle strobe. The selected digit counter increments once per strobe.
- blink_on, output, 1: 1 = show the selected digit, 0 = blank it.
- run_enable, output, 1: 1 when selected == 0. Gates the decisecond prescaler.

## Operation
- **Input conditioning.** Each key passes through a 2-flop synchronizer and then a debouncer.
  - Debouncer: a counter clears whenever the synchronized level differs from the held level.
  - When the counter reaches DEBOUNCE_CYCLES-1, the held level updates and the counter clears.
  - A press event is a held-level transition 1→0. Releases generate no event.
- **Select FSM.** States are the seven `selected` codes.
  - A select press moves to the next code: 0→1→2→3→4→5→6→0.
  - Codes 7–15 are unreachable. If entered, the FSM returns to 0 on the next cycle.
- **Advance.**
  - An advance press with selected != 0 raises advance_pulse for exactly one cycle.
  - An advance press with selected == 0 is ignored.
  - No auto-repeat: holding the key gives exactly one pulse.
- **Simultaneous press events in the same cycle.** Select wins. The advance event is discarded and advance_pulse stays 0.
- **Blink.**
  - With selected == 0: blink_on = 1 and the blink counter is held at 0.
  - Otherwise blink_on toggles each time the counter reaches BLINK_HALF_PERIOD-1.
  - Any accepted select or advance press forces blink_on = 1 and clears the counter, so the changed digit is shown immediately.
- **run_enable.** Equals (selected == 0), registered together with selected.
- **Reset values.**
  - selected = 0, advance_pulse = 0, blink_on = 1, run_enable = 1.
  - Debounced levels = 1 (released). All counters = 0.
  - Synchronizer flops = 1.
- **Reset asserted mid-operation** (e.g. during a press or in state 4): all of the above are restored on the next edge. A key still held at reset release produces no press event until it is released and pressed again.

## Timing
- Press latency: the raw falling edge, held stable, produces the FSM update or advance_pulse exactly 2 + DEBOUNCE_CYCLES + 1 cycles later.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- All outputs are registered. selected, run_enable and blink_on change on the same edge as the accepted press; advance_pulse is asserted in that same cycle.
- Minimum spacing between two advance_pulse strobes: 2 × DEBOUNCE_CYCLES cycles (a press plus a release must each debounce).
- Blink period with no activity: 2 × BLINK_HALF_PERIOD cycles.

## Configuration
- Macro: TIME_SET_TIMEOUT_EN.
- **Defined.**
  - An idle counter runs while selected != 0 and clears on any accepted press and whenever selected == 0.
  - When it reaches TIMEOUT_CYCLES-1, the next edge sets selected = 0, run_enable = 1 and blink_on = 1.
  - If a press event coincides with the timeout edge, the press wins and the idle counter clears.
- **Undefined.** No idle counter and no TIMEOUT_CYCLES parameter. Setting mode persists until six further select presses wrap the code to 0.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=8, TIMEOUT_CYCLES=32, TIME_SET_TIMEOUT_EN defined.
- Reset: hold reset 3 cycles, keys high → selected=0, advance_pulse=0, blink_on=1, run_enable=1.
- Select sequencing:
  - 7 clean select presses → selected steps 1,2,3,4,5,6,0.
  - Each step lands exactly 7 cycles after the raw falling edge.
  - run_enable=0 for codes 1–6.
- Bounce and debounce:
  - Select bounces 1–3 cycles wide for 20 cycles, then held low → exactly one transition 0→1.
  - A 3-cycle pulse alone → no change.
- Advance:
  - In state 3, a press held 50 cycles → advance_pulse high exactly 1 cycle and blink_on=1 that cycle.
  - Advance pressed in state 0 → no pulse.
- Same-cycle press events: select and advance falling on the same cycle → selected increments, advance_pulse stays 0.
- Blink and timeout:
  - In state 2 with no input → blink_on toggles every 8 cycles.
  - After 32 idle cycles → selected=0, run_enable=1, blink_on=1.
  - With TIME_SET_TIMEOUT_EN undefined, the same stimulus leaves selected=2 after 1000 cycles.

Source files
------------

// File: rtl/time_set_controller_if.sv
// Set-time interface between the KEY pins and the digit counter / blinker chain.
// master drives the raw keys, slave is the controller producing the set-time outputs.
interface time_set_controller_if;
   logic       select_key_n;
   logic       advance_key_n;
   logic [3:0] selected;
   logic       advance_pulse;
   logic       blink_on;
   logic       run_enable;

   modport master (
      output select_key_n, advance_key_n,
      input  selected, advance_pulse, blink_on, run_enable
   );

   modport slave (
      input  select_key_n, advance_key_n,
      output selected, advance_pulse, blink_on, run_enable
   );
endinterface

// File: rtl/time_set_controller.sv
// Two-button set-time sequencer: debounced select/advance keys, field FSM, blink and run-enable.
// Optional idle timeout back to run mode is enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_controller #(
   parameter logic [19:0] DEBOUNCE_CYCLES   = 20'd500_000,
   parameter logic [24:0] BLINK_HALF_PERIOD = 25'd12_500_000
`ifdef TIME_SET_TIMEOUT_EN
   ,
   parameter logic [29:0] TIMEOUT_CYCLES    = 30'd500_000_000
`endif
) (
   input logic                  inputClock,
   input logic                  reset,
   time_set_controller_if.slave bus
);

   typedef enum logic [3:0] {
      SEL_NONE        = 4'd0,
      SEL_SECONDS     = 4'd1,
      SEL_SECONDS_X10 = 4'd2,
      SEL_MINUTES     = 4'd3,
      SEL_MINUTES_X10 = 4'd4,
      SEL_HOURS       = 4'd5,
      SEL_HOURS_X10   = 4'd6
   } sel_state_t;

   // Bit 0 is the select key, bit 1 the advance key.
   logic [1:0]  key_raw_s;
   logic [1:0]  sync1_r;
   logic [1:0]  sync2_r;
   logic [1:0]  held_r;
   logic [1:0]  held_d_r;
   logic [1:0]  armed_r;
   logic [19:0] deb_cnt_r [2];
   logic [19:0] arm_cnt_r [2];
   logic [1:0]  press_s;
   logic        select_press_s;
   logic        advance_press_s;
   logic        timeout_s;

   sel_state_t  state_r;
   sel_state_t  step_s;
   sel_state_t  next_state_s;
   logic        advance_pulse_r;
   logic        blink_on_r;
   logic        run_enable_r;
   logic [24:0] blink_cnt_r;

   assign key_raw_s = {bus.advance_key_n, bus.select_key_n};

   // Synchronize and debounce both keys; a key only becomes armed after a stable release,
   // so a key still held across reset cannot produce a press.
   always_ff @(posedge inputClock) begin
      if (reset) begin
         sync1_r  <= 2'b11;
         sync2_r  <= 2'b11;
         held_r   <= 2'b11;
         held_d_r <= 2'b11;
         armed_r  <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            deb_cnt_r[k] <= 20'd0;
            arm_cnt_r[k] <= 20'd0;
         end
      end else begin
         sync1_r  <= key_raw_s;
         sync2_r  <= sync1_r;
         held_d_r <= held_r;
         for (int k = 0; k < 2; k++) begin
            if (sync2_r[k] != held_r[k]) begin
               arm_cnt_r[k] <= 20'd0;
               if (deb_cnt_r[k] == DEBOUNCE_CYCLES - 20'd1) begin
                  held_r[k]    <= sync2_r[k];
                  deb_cnt_r[k] <= 20'd0;
                  if (sync2_r[k]) begin
                     armed_r[k] <= 1'b1;
                  end else begin
                     armed_r[k] <= armed_r[k];
                  end
               end else begin
                  deb_cnt_r[k] <= deb_cnt_r[k] + 20'd1;
               end
            end else begin
               deb_cnt_r[k] <= 20'd0;
               if (!armed_r[k] && sync2_r[k]) begin
                  if (arm_cnt_r[k] == DEBOUNCE_CYCLES - 20'd1) begin
                     armed_r[k]   <= 1'b1;
                     arm_cnt_r[k] <= 20'd0;
                  end else begin
                     arm_cnt_r[k] <= arm_cnt_r[k] + 20'd1;
                  end
               end else begin
                  arm_cnt_r[k] <= 20'd0;
               end
            end
         end
      end
   end

   assign press_s         = armed_r & held_d_r & ~held_r;
   assign select_press_s  = press_s[0];
   assign advance_press_s = press_s[1] & ~press_s[0] &
                            (state_r != SEL_NONE) & (state_r <= SEL_HOURS_X10);

   // Field sequencing on a select press; unreachable codes fall back to NONE.
   always_comb begin
      step_s = SEL_NONE;
      case (state_r)
         SEL_NONE:        step_s = select_press_s ? SEL_SECONDS     : SEL_NONE;
         SEL_SECONDS:     step_s = select_press_s ? SEL_SECONDS_X10 : SEL_SECONDS;
         SEL_SECONDS_X10: step_s = select_press_s ? SEL_MINUTES     : SEL_SECONDS_X10;
         SEL_MINUTES:     step_s = select_press_s ? SEL_MINUTES_X10 : SEL_MINUTES;
         SEL_MINUTES_X10: step_s = select_press_s ? SEL_HOURS       : SEL_MINUTES_X10;
         SEL_HOURS:       step_s = select_press_s ? SEL_HOURS_X10   : SEL_HOURS;
         SEL_HOURS_X10:   step_s = select_press_s ? SEL_NONE        : SEL_HOURS_X10;
         default:         step_s = SEL_NONE;
      endcase
   end

   assign next_state_s = (timeout_s && !select_press_s && !advance_press_s) ? SEL_NONE : step_s;

`ifdef TIME_SET_TIMEOUT_EN
   logic [29:0] idle_cnt_r;

   assign timeout_s = (idle_cnt_r == TIMEOUT_CYCLES - 30'd1);

   // Idle counter: runs only while a field is being set and no press arrives.
   always_ff @(posedge inputClock) begin
      if (reset) begin
         idle_cnt_r <= 30'd0;
      end else if ((next_state_s == SEL_NONE) || select_press_s || advance_press_s) begin
         idle_cnt_r <= 30'd0;
      end else begin
         idle_cnt_r <= idle_cnt_r + 30'd1;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Field register with its registered outputs: strobe, blink phase and run-enable.
   always_ff @(posedge inputClock) begin
      if (reset) begin
         state_r         <= SEL_NONE;
         advance_pulse_r <= 1'b0;
         blink_on_r      <= 1'b1;
         run_enable_r    <= 1'b1;
         blink_cnt_r     <= 25'd0;
      end else begin
         state_r         <= next_state_s;
         advance_pulse_r <= advance_press_s;
         run_enable_r    <= (next_state_s == SEL_NONE);
         if ((next_state_s == SEL_NONE) || select_press_s || advance_press_s) begin
            blink_on_r  <= 1'b1;
            blink_cnt_r <= 25'd0;
         end else if (blink_cnt_r == BLINK_HALF_PERIOD - 25'd1) begin
            blink_on_r  <= ~blink_on_r;
            blink_cnt_r <= 25'd0;
         end else begin
            blink_on_r  <= blink_on_r;
            blink_cnt_r <= blink_cnt_r + 25'd1;
         end
      end
   end

   assign bus.selected      = state_r;
   assign bus.advance_pulse = advance_pulse_r;
   assign bus.blink_on      = blink_on_r;
   assign bus.run_enable    = run_enable_r;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: vector table of key presses plus
// hand-written sequences for bounce, glitch, hold, blink, timeout and mid-press reset.
module tb_time_set_controller;

   typedef struct {
      logic       ps;
      logic       pa;
      logic [3:0] exp_sel;
      logic       exp_run;
      int         exp_pulses;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   int         w_changes;
   int         w_pulses;
   logic       w_pulse_blink;
   logic [3:0] w_prev;

   time_set_controller_if bus ();

   time_set_controller #(
      .DEBOUNCE_CYCLES  (20'd4),
      .BLINK_HALF_PERIOD(25'd8)
`ifdef TIME_SET_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES   (30'd32)
`endif
   ) dut (
      .inputClock(clk),
      .reset     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.select_key_n  = 1'b1;
      bus.advance_key_n = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
   endtask

   // Advance n cycles, counting selected changes and advance strobes.
   task automatic watch(input int n);
      for (int c = 0; c < n; c++) begin
         tick(1);
         if (bus.advance_pulse) begin
            w_pulses++;
            w_pulse_blink = bus.blink_on;
         end
         if (bus.selected != w_prev) begin
            w_changes++;
            w_prev = bus.selected;
         end
      end
   endtask

   task automatic run_press(input logic ps, input logic pa,
                            output int change_cycle, output int pulse_cycle,
                            output int pulses, output logic blink_evt);
      logic [3:0] prev;
      prev         = bus.selected;
      change_cycle = 0;
      pulse_cycle  = 0;
      pulses       = 0;
      blink_evt    = 1'b0;
      bus.select_key_n  = ~ps;
      bus.advance_key_n = ~pa;
      for (int c = 1; c <= 18; c++) begin
         tick(1);
         if (bus.advance_pulse) begin
            pulses++;
            if (pulse_cycle == 0) begin
               pulse_cycle = c;
               blink_evt   = bus.blink_on;
            end
         end
         if (bus.selected != prev) begin
            if (change_cycle == 0) begin
               change_cycle = c;
               blink_evt    = bus.blink_on;
            end
            prev = bus.selected;
         end
         if (c == 9) begin
            bus.select_key_n  = 1'b1;
            bus.advance_key_n = 1'b1;
         end
      end
   endtask

   initial begin
      vec_t vecs [12];
      int   seg [11];
      int   chg_c;
      int   pls_c;
      int   pls;
      logic blk;

      vecs[0]  = '{1'b1, 1'b0, 4'd1, 1'b0, 0};
      vecs[1]  = '{1'b1, 1'b0, 4'd2, 1'b0, 0};
      vecs[2]  = '{1'b1, 1'b0, 4'd3, 1'b0, 0};
      vecs[3]  = '{1'b1, 1'b0, 4'd4, 1'b0, 0};
      vecs[4]  = '{1'b1, 1'b0, 4'd5, 1'b0, 0};
      vecs[5]  = '{1'b1, 1'b0, 4'd6, 1'b0, 0};
      vecs[6]  = '{1'b1, 1'b0, 4'd0, 1'b1, 0};
      vecs[7]  = '{1'b0, 1'b1, 4'd0, 1'b1, 0};
      vecs[8]  = '{1'b1, 1'b0, 4'd1, 1'b0, 0};
      vecs[9]  = '{1'b0, 1'b1, 4'd1, 1'b0, 1};
      vecs[10] = '{1'b1, 1'b1, 4'd2, 1'b0, 0};
      vecs[11] = '{1'b0, 1'b1, 4'd2, 1'b0, 1};

      seg = '{1, 2, 3, 1, 2, 3, 3, 1, 1, 2, 2};

      // Reset state
      rst = 1'b1;
      bus.select_key_n  = 1'b1;
      bus.advance_key_n = 1'b1;
      tick(3);
      check("reset_selected", bus.selected, 0);
      check("reset_pulse", bus.advance_pulse, 0);
      check("reset_blink", bus.blink_on, 1);
      check("reset_run_enable", bus.run_enable, 1);
      rst = 1'b0;
      tick(2);
      check("post_reset_selected", bus.selected, 0);

      // Vector table: each record is one press with a 7-cycle landing check
      for (int i = 0; i < 12; i++) begin
         run_press(vecs[i].ps, vecs[i].pa, chg_c, pls_c, pls, blk);
         check($sformatf("vec%0d_selected", i), bus.selected, vecs[i].exp_sel);
         check($sformatf("vec%0d_run_enable", i), bus.run_enable, vecs[i].exp_run);
         check($sformatf("vec%0d_pulses", i), pls, vecs[i].exp_pulses);
         if (vecs[i].ps) begin
            check($sformatf("vec%0d_change_latency", i), chg_c, 7);
            check($sformatf("vec%0d_blink_at_change", i), blk, 1);
         end else if (vecs[i].exp_pulses > 0) begin
            check($sformatf("vec%0d_pulse_latency", i), pls_c, 7);
            check($sformatf("vec%0d_blink_at_pulse", i), blk, 1);
         end else begin
            check($sformatf("vec%0d_no_change", i), chg_c, 0);
         end
      end

      // 3-cycle glitch alone produces nothing
      apply_reset();
      tick(4);
      w_changes = 0; w_pulses = 0; w_prev = bus.selected;
      bus.select_key_n = 1'b0;
      watch(3);
      bus.select_key_n = 1'b1;
      watch(15);
      check("glitch_changes", w_changes, 0);
      check("glitch_selected", bus.selected, 0);

      // Bouncy select followed by a solid press gives exactly one step
      w_changes = 0; w_prev = bus.selected;
      for (int i = 0; i < 11; i++) begin
         bus.select_key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         watch(seg[i]);
      end
      bus.select_key_n = 1'b0;
      watch(20);
      bus.select_key_n = 1'b1;
      watch(10);
      check("bounce_changes", w_changes, 1);
      check("bounce_selected", bus.selected, 1);

      // Advance held 50 cycles in field 3
      apply_reset();
      tick(4);
      for (int i = 0; i < 3; i++) run_press(1'b1, 1'b0, chg_c, pls_c, pls, blk);
      check("hold_state3", bus.selected, 3);
      w_changes = 0; w_pulses = 0; w_pulse_blink = 1'b0; w_prev = bus.selected;
      bus.advance_key_n = 1'b0;
      watch(50);
      bus.advance_key_n = 1'b1;
      watch(10);
      check("hold_pulses", w_pulses, 1);
      check("hold_blink_at_pulse", w_pulse_blink, 1);

      // Advance in field 0 is ignored
      apply_reset();
      tick(4);
      w_changes = 0; w_pulses = 0; w_prev = bus.selected;
      bus.advance_key_n = 1'b0;
      watch(20);
      bus.advance_key_n = 1'b1;
      watch(10);
      check("adv_idle_pulses", w_pulses, 0);
      check("adv_idle_selected", bus.selected, 0);

      // Blink cadence in field 2, then timeout (or persistence without it)
      apply_reset();
      tick(4);
      run_press(1'b1, 1'b0, chg_c, pls_c, pls, blk);
      run_press(1'b1, 1'b0, chg_c, pls_c, pls, blk);
      check("blink_state2", bus.selected, 2);
      check("blink_entry_latency", chg_c, 7);
      for (int k = 11; k < 32; k++) begin
         check($sformatf("blink_k%0d", k), bus.blink_on, ((k / 8) % 2 == 0) ? 1 : 0);
         check($sformatf("blink_sel_k%0d", k), bus.selected, 2);
         tick(1);
      end
`ifdef TIME_SET_TIMEOUT_EN
      check("timeout_selected", bus.selected, 0);
      check("timeout_run_enable", bus.run_enable, 1);
      check("timeout_blink", bus.blink_on, 1);
`else
      tick(1000 - 32);
      check("persist_selected", bus.selected, 2);
      check("persist_run_enable", bus.run_enable, 0);
`endif

      // Reset mid-press with the key still held: no event until re-pressed
      apply_reset();
      tick(4);
      run_press(1'b1, 1'b0, chg_c, pls_c, pls, blk);
      check("midreset_state1", bus.selected, 1);
      bus.select_key_n = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("midreset_selected", bus.selected, 0);
      check("midreset_run_enable", bus.run_enable, 1);
      w_changes = 0; w_pulses = 0; w_prev = bus.selected;
      watch(20);
      check("midreset_held_changes", w_changes, 0);
      bus.select_key_n = 1'b1;
      tick(10);
      run_press(1'b1, 1'b0, chg_c, pls_c, pls, blk);
      check("midreset_repress_selected", bus.selected, 1);
      check("midreset_repress_latency", chg_c, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
